// File: rtl/mem_rd_stream.sv
// mem_rd_stream: reads a burst of consecutive words from an 8x1024 synchronous
// memory and presents them as a valid/ready stream. A 2-entry buffer plus a
// bypass from the memory read port absorbs the read latency. Reads are credit
// limited, so downstream back-pressure never overflows the buffer.
module mem_rd_stream (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  base_addr,
  input  logic [10:0] len,
  output logic [9:0]  mem_addr,
  output logic        mem_wr,
  input  logic [7:0]  mem_d_o,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state, state_nxt;

  logic [10:0] len_req;     // requested length clamped to 1024
  logic [10:0] len_eff;     // latched effective burst length
  logic [10:0] issue_left;  // reads not yet issued
  logic [10:0] beat_cnt;    // index of the beat at the stream head
  logic [9:0]  next_addr;   // address of the next read to issue

  // rd_p1: an address sits in mem_addr and is sampled by the memory on the
  // next edge. rd_p2: that read's data is on mem_d_o during this cycle.
  logic        rd_p1, rd_p2;

  logic [7:0]  buf_q [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;

  logic        pop, issue, push, drain;
  logic [2:0]  credit;

  assign len_req = (len > 11'd1024) ? 11'd1024 : len;
  assign mem_wr  = 1'b0;
  assign busy    = (state != IDLE);
  assign done    = (state == FIN);

  // The head of the stream is the oldest buffered word, or the word arriving
  // from memory when the buffer is empty. Both sources are register-timed, so
  // m_valid never depends on m_ready.
  assign m_valid = (count != 2'd0) || rd_p2;
  assign m_data  = ((count == 2'd0) && rd_p2) ? mem_d_o : buf_q[rd_ptr];
  assign m_last  = m_valid && (beat_cnt == len_eff - 11'd1);
  assign pop     = m_valid && m_ready;

  // Words held plus reads in flight. The beat leaving this cycle returns its
  // credit immediately. That keeps a full-rate stream going with only two
  // credits, and the total committed never exceeds the buffer depth.
  assign credit = {1'b0, count} + {2'b00, rd_p1} + {2'b00, rd_p2};
  assign issue  = (state == RUN) && (issue_left != 11'd0) &&
                  (credit < (pop ? 3'd3 : 3'd2));

  // Arriving data is stored unless it leaves straight through the bypass.
  assign push  = rd_p2 && !(pop && (count == 2'd0));
  assign drain = pop && (count != 2'd0);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, whatever the statement order.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment first means every path assigns state_nxt,
    // so no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = (len == 11'd0) ? FIN : RUN;
      RUN:  if (pop && m_last) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping, read issue and the read-latency pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_eff    <= 11'd0;
      issue_left <= 11'd0;
      beat_cnt   <= 11'd0;
      next_addr  <= 10'd0;
      mem_addr   <= 10'd0;
      rd_p1      <= 1'b0;
      rd_p2      <= 1'b0;
    end else begin
      if ((state == IDLE) && start && (len != 11'd0)) begin
        len_eff    <= len_req;
        issue_left <= len_req;
        beat_cnt   <= 11'd0;
        next_addr  <= base_addr;
      end
      if (issue) begin
        mem_addr   <= next_addr;
        next_addr  <= next_addr + 10'd1;  // wraps 1023 -> 0
        issue_left <= issue_left - 11'd1;
      end
      if (pop) beat_cnt <= beat_cnt + 11'd1;
      rd_p1 <= issue;
      rd_p2 <= rd_p1;
    end
  end

  // Output buffer storage and pointers.
  always_ff @(posedge clk) begin
    // NOTE: the two buffer words are cleared on reset because m_data shows
    // buf_q[rd_ptr] while idle and must read 0 after reset. A larger RAM
    // would not be reset.
    if (reset) begin
      buf_q[0] <= 8'd0;
      buf_q[1] <= 8'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wr_ptr] <= mem_d_o;
        wr_ptr        <= ~wr_ptr;
      end
      if (drain) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, drain};
    end
  end

endmodule

// File: tb/tb_mem_rd_stream.sv
// Directed bench for mem_rd_stream. A behavioural 8x1024 synchronous memory
// is preloaded with mem[a] = a[7:0], so the expected data is the low byte of
// each address.
module tb_mem_rd_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] len;
  logic [9:0]  mem_addr;
  logic        mem_wr;
  logic [7:0]  mem_d_o;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  mem_rd_stream dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_d_o   (mem_d_o),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  // Synchronous-read memory model.
  logic [7:0] mem [1024];
  initial for (int a = 0; a < 1024; a++) mem[a] = a[7:0];
  always @(posedge clk) mem_d_o <= mem[mem_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Observations from the most recent burst.
  logic [7:0] beat_data [$];
  logic       beat_last [$];
  int         beat_cyc  [$];
  int         addr_log  [$];
  int         first_valid, done_cnt, done_cyc, stall_err, busy_c0, busy_after;
  bit         timed_out;
  logic [7:0] pat = 8'b1010_1001;  // m_ready per cycle, bit 0 first: 1,0,0,1,0,1,0,1

  // Pulse start for one edge, then watch the stream until the cycle after done.
  task automatic run_burst(input logic [9:0] b, input logic [10:0] l,
                           input bit toggle, input int bound);
    logic       held;
    logic [7:0] held_d;
    logic       held_l;
    logic       rdy;
    bit         done_seen;
    int         prev_addr;
    beat_data.delete(); beat_last.delete(); beat_cyc.delete(); addr_log.delete();
    first_valid = -1; done_cnt = 0; done_cyc = -1; stall_err = 0;
    busy_c0 = 0; busy_after = -1; timed_out = 1'b1;
    held = 1'b0; held_d = 8'd0; held_l = 1'b0; done_seen = 1'b0;
    base_addr = b; len = l; start = 1'b1; m_ready = 1'b1;
    tick();
    start = 1'b0;
    prev_addr = int'(mem_addr);
    for (int c = 0; c < bound; c++) begin
      if (c == 0) busy_c0 = int'(busy);
      if (int'(mem_addr) != prev_addr) begin
        addr_log.push_back(int'(mem_addr));
        prev_addr = int'(mem_addr);
      end
      if (held && ((m_data !== held_d) || (m_last !== held_l) || !m_valid)) stall_err++;
      if (m_valid && first_valid < 0) first_valid = c;
      if (done) begin
        done_cnt++;
        if (!done_seen) done_cyc = c;
        done_seen = 1'b1;
      end else if (done_seen) begin
        busy_after = int'(busy);
        timed_out  = 1'b0;
        break;
      end
      rdy = toggle ? pat[c % 8] : 1'b1;
      m_ready = rdy;
      if (m_valid && rdy) begin
        beat_data.push_back(m_data);
        beat_last.push_back(m_last);
        beat_cyc.push_back(c);
      end
      held   = m_valid && !rdy;
      held_d = m_data;
      held_l = m_last;
      tick();
    end
    m_ready = 1'b0;
    check("timeout", {31'd0, timed_out}, 32'd0);
  endtask

  // Compare the captured beats with the preloaded memory pattern.
  task automatic check_beats(input string tag, input int b, input int n);
    int m;
    check({tag, "_nbeats"}, beat_data.size(), n);
    m = (beat_data.size() < n) ? beat_data.size() : n;
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_data%0d", tag, i), {24'd0, beat_data[i]}, ((b + i) % 1024) & 32'hFF);
      check($sformatf("%s_last%0d", tag, i), {31'd0, beat_last[i]}, (i == n - 1) ? 32'd1 : 32'd0);
    end
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_busy_after"}, busy_after, 0);
  endtask

  initial begin
    int viol;
    reset = 1'b1; start = 1'b0; base_addr = 10'd0; len = 11'd0; m_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_m_valid",  {31'd0, m_valid}, 32'd0);
    check("rst_m_last",   {31'd0, m_last},  32'd0);
    check("rst_m_data",   {24'd0, m_data},  32'd0);
    check("rst_busy",     {31'd0, busy},    32'd0);
    check("rst_done",     {31'd0, done},    32'd0);
    check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_mem_wr",   {31'd0, mem_wr},  32'd0);

    // Basic burst: 05,06,07,08 back to back, first valid two edges after start.
    run_burst(10'd5, 11'd4, 1'b0, 40);
    check_beats("b5", 5, 4);
    check("b5_first_valid", first_valid, 2);
    check("b5_no_bubble", (beat_cyc.size() == 4) ? beat_cyc[3] - beat_cyc[0] : -1, 3);
    check("b5_done_cyc", done_cyc, 6);

    // Address wrap: FE,FF,00,01 from addresses 1022,1023,0,1.
    run_burst(10'd1022, 11'd4, 1'b0, 40);
    check_beats("wrap", 1022, 4);
    check("wrap_naddr", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check("wrap_addr0", addr_log[0], 1022);
      check("wrap_addr1", addr_log[1], 1023);
      check("wrap_addr2", addr_log[2], 0);
      check("wrap_addr3", addr_log[3], 1);
    end

    // Back-pressure: all 8 beats in order, data held while stalled.
    run_burst(10'd300, 11'd8, 1'b1, 100);
    check_beats("bp", 300, 8);
    check("bp_stall_hold", stall_err, 0);
    check("bp_mem_wr", {31'd0, mem_wr}, 32'd0);

    // Empty burst: no data, busy and done for exactly one cycle.
    run_burst(10'd40, 11'd0, 1'b0, 20);
    check("len0_first_valid", first_valid, -1);
    check("len0_busy_c0", busy_c0, 1);
    check("len0_done_cyc", done_cyc, 0);
    check("len0_done_cnt", done_cnt, 1);
    check("len0_busy_after", busy_after, 0);

    // Oversized request clamps to 1024 beats.
    run_burst(10'd0, 11'd2000, 1'b0, 1200);
    check_beats("big", 0, 1024);
    check("big_no_bubble", (beat_cyc.size() == 1024) ? beat_cyc[1023] - beat_cyc[0] : -1, 1023);

    // Reset three cycles into a 16-beat burst.
    base_addr = 10'd100; len = 11'd16; start = 1'b1; m_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_m_valid",  {31'd0, m_valid}, 32'd0);
    check("abort_m_last",   {31'd0, m_last},  32'd0);
    check("abort_m_data",   {24'd0, m_data},  32'd0);
    check("abort_busy",     {31'd0, busy},    32'd0);
    check("abort_done",     {31'd0, done},    32'd0);
    check("abort_mem_addr", {22'd0, mem_addr}, 32'd0);
    check("abort_mem_wr",   {31'd0, mem_wr},  32'd0);
    viol = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done || m_valid || busy) viol++;
    end
    check("abort_quiet", viol, 0);
    run_burst(10'd200, 11'd3, 1'b0, 40);
    check_beats("restart", 200, 3);
    check("restart_first_valid", first_valid, 2);

    // Reset wins over start on the same edge.
    reset = 1'b1; start = 1'b1; base_addr = 10'd7; len = 11'd5;
    tick();
    reset = 1'b0; start = 1'b0;
    check("prio_busy", {31'd0, busy}, 32'd0);
    tick();
    check("prio_busy2", {31'd0, busy}, 32'd0);
    check("prio_m_valid", {31'd0, m_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
